// File: rtl/puf_ram_arbiter.sv
// Two-port arbiter sharing one combined RAM between the PUF readout engine (port 0) and a secondary requester.
// Optional write guard, which protects the SRAM start-up pattern, is built only when PUF_RAM_WRITE_GUARD_EN is defined.
module puf_ram_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m0_wmask,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [DATA_W-1:0] m1_wmask,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] ram_wmask,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              puf_release,
  output logic              guard_active,
  output logic              wr_blocked
);

  logic              last;
  logic              rd_pend;
  logic              rd_owner;
  logic              sel;
  logic              any;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic [DATA_W-1:0] win_wmask;

  // On a tie, the port that did not win last time is served.
  always_comb begin
    sel = 1'b0;
    if (m0_req && m1_req) sel = ~last;
    else                  sel = m1_req;
    any       = rst_n & (m0_req | m1_req);
    win_we    = sel ? m1_we    : m0_we;
    win_addr  = sel ? m1_addr  : m0_addr;
    win_wdata = sel ? m1_wdata : m0_wdata;
    win_wmask = sel ? m1_wmask : m0_wmask;
  end

  assign m0_gnt    = any & ~sel;
  assign m1_gnt    = any & sel;
  assign ram_raddr = any ? win_addr  : '0;
  assign ram_waddr = any ? win_addr  : '0;
  assign ram_wdata = any ? win_wdata : '0;
  assign ram_wmask = any ? win_wmask : '0;
  assign ram_we    = any & win_we & ~guard_active;

  assign m0_rvalid = rst_n & rd_pend & ~rd_owner;
  assign m1_rvalid = rst_n & rd_pend & rd_owner;
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last     <= 1'b1;
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend <= any & ~win_we;
      if (any) begin
        last <= sel;
        if (!win_we) rd_owner <= sel;
      end
    end
  end

`ifdef PUF_RAM_WRITE_GUARD_EN
  typedef enum logic {GUARDED, OPEN} guard_state_t;
  guard_state_t guard_state;

  // A write granted in the release cycle still sees guard_active = 1 and is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      guard_state  <= GUARDED;
      guard_active <= 1'b1;
      wr_blocked   <= 1'b0;
    end else begin
      wr_blocked <= wr_blocked | (any & win_we & guard_active);
      case (guard_state)
        GUARDED: begin
          if (puf_release) begin
            guard_state  <= OPEN;
            guard_active <= 1'b0;
          end
        end
        OPEN: guard_active <= 1'b0;
        default: begin
          guard_state  <= GUARDED;
          guard_active <= 1'b1;
        end
      endcase
    end
  end
`else
  logic unused_release;
  assign unused_release = puf_release;
  assign guard_active   = 1'b0;
  assign wr_blocked     = 1'b0;
`endif

endmodule

// File: tb/tb_puf_ram_arbiter.sv
// Directed bench for puf_ram_arbiter; expected guard behaviour follows PUF_RAM_WRITE_GUARD_EN.
module tb_puf_ram_arbiter;
  localparam int AW = 13;
  localparam int DW = 16;
`ifdef PUF_RAM_WRITE_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m0_wmask, m1_wdata, m1_wmask;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata, ram_wmask;
  logic [DW-1:0] ram_rdata = '0;
  logic          puf_release;
  logic          guard_active, wr_blocked;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  puf_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_rdata(ram_rdata),
    .puf_release(puf_release), .guard_active(guard_active), .wr_blocked(wr_blocked)
  );

  // RAM model: fixed start-up contents, masked writes, one-cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          written [0:(1<<AW)-1];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    case (a)
      13'h0005: return 16'hA55A;
      13'h0001: return 16'h1111;
      13'h0002: return 16'h2222;
      default:  return 16'h0000;
    endcase
  endfunction

  function automatic logic [DW-1:0] cur(input logic [AW-1:0] a);
    return (written[a] === 1'b1) ? mem[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    ram_rdata <= cur(ram_raddr);
    if (ram_we) begin
      mem[ram_waddr]     <= (cur(ram_waddr) & ram_wmask) | (ram_wdata & ~ram_wmask);
      written[ram_waddr] <= 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_wmask = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0;
    puf_release = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    m0_req = 1; m1_req = 1; m0_we = 1; m1_we = 1;
    step();
    step();
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_err++; $display("FAIL reset_gnt: got %b want 00", {m0_gnt, m1_gnt}); end
    n_cmp++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_err++; $display("FAIL reset_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    n_cmp++; if (guard_active !== GUARD) begin n_err++; $display("FAIL reset_guard: got %b want %b", guard_active, GUARD); end
    n_cmp++; if (wr_blocked !== 1'b0) begin n_err++; $display("FAIL reset_wr_blocked: got %b want 0", wr_blocked); end
    idle_inputs();
    rst_n = 1;
    step();
  endtask

  task automatic test_single_read();
    m0_req = 1; m0_we = 0; m0_addr = 13'h0005;
    #1;
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_err++; $display("FAIL read_gnt: got %b want 10", {m0_gnt, m1_gnt}); end
    n_cmp++; if (ram_raddr !== 13'h0005) begin n_err++; $display("FAIL read_raddr: got %h want 0005", ram_raddr); end
    n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL read_ram_we: got %b want 0", ram_we); end
    step();
    idle_inputs();
    #1;
    n_cmp++; if (m0_rvalid !== 1'b1) begin n_err++; $display("FAIL read_m0_rvalid: got %b want 1", m0_rvalid); end
    n_cmp++; if (m0_rdata !== 16'hA55A) begin n_err++; $display("FAIL read_m0_rdata: got %h want a55a", m0_rdata); end
    n_cmp++; if (m1_rvalid !== 1'b0) begin n_err++; $display("FAIL read_m1_rvalid: got %b want 0", m1_rvalid); end
    n_cmp++; if (ram_raddr !== '0) begin n_err++; $display("FAIL idle_raddr: got %h want 0000", ram_raddr); end
    step();
    n_cmp++; if (m0_rvalid !== 1'b0) begin n_err++; $display("FAIL read_rvalid_once: got %b want 0", m0_rvalid); end
  endtask

  task automatic test_contention();
    do_reset();
    m0_req = 1; m0_we = 0; m0_addr = 13'h0001;
    m1_req = 1; m1_we = 0; m1_addr = 13'h0002;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if ({m0_gnt, m1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL contend_gnt[%0d]: got %b want %b", i, {m0_gnt, m1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      step();
      n_cmp++;
      if ({m0_rvalid, m1_rvalid} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        n_err++; $display("FAIL contend_rvalid[%0d]: got %b want %b", i, {m0_rvalid, m1_rvalid}, (i % 2 == 0) ? 2'b10 : 2'b01);
      end
      n_cmp++;
      if (m0_rdata !== ((i % 2 == 0) ? 16'h1111 : 16'h2222)) begin
        n_err++; $display("FAIL contend_rdata[%0d]: got %h want %h", i, m0_rdata, (i % 2 == 0) ? 16'h1111 : 16'h2222);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_guard();
    m1_req = 1; m1_we = 1; m1_addr = 13'h0010; m1_wdata = 16'hBEEF; m1_wmask = '0;
    #1;
    n_cmp++; if (m1_gnt !== 1'b1) begin n_err++; $display("FAIL guard_gnt: got %b want 1", m1_gnt); end
    n_cmp++; if (ram_we !== ~GUARD) begin n_err++; $display("FAIL guard_ram_we: got %b want %b", ram_we, ~GUARD); end
    step();
    idle_inputs();
    #1;
    n_cmp++; if (wr_blocked !== GUARD) begin n_err++; $display("FAIL guard_wr_blocked: got %b want %b", wr_blocked, GUARD); end
    n_cmp++; if (m1_rvalid !== 1'b0) begin n_err++; $display("FAIL guard_write_rvalid: got %b want 0", m1_rvalid); end
    puf_release = 1;
    step();
    puf_release = 0;
    #1;
    n_cmp++; if (guard_active !== 1'b0) begin n_err++; $display("FAIL guard_open: got %b want 0", guard_active); end
    m1_req = 1; m1_we = 1; m1_addr = 13'h0010; m1_wdata = 16'hBEEF; m1_wmask = '0;
    #1;
    n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL open_ram_we: got %b want 1", ram_we); end
    n_cmp++; if (ram_waddr !== 13'h0010) begin n_err++; $display("FAIL open_waddr: got %h want 0010", ram_waddr); end
    n_cmp++; if (ram_wdata !== 16'hBEEF) begin n_err++; $display("FAIL open_wdata: got %h want beef", ram_wdata); end
    step();
    idle_inputs();
    #1;
    n_cmp++; if (mem[13'h0010] !== 16'hBEEF) begin n_err++; $display("FAIL open_mem: got %h want beef", mem[13'h0010]); end
    n_cmp++; if (wr_blocked !== GUARD) begin n_err++; $display("FAIL open_wr_blocked_sticky: got %b want %b", wr_blocked, GUARD); end
  endtask

  task automatic test_release_collision();
    do_reset();
    puf_release = 1;
    m1_req = 1; m1_we = 1; m1_addr = 13'h0020; m1_wdata = 16'h1234; m1_wmask = '0;
    #1;
    n_cmp++; if (ram_we !== ~GUARD) begin n_err++; $display("FAIL collide_ram_we: got %b want %b", ram_we, ~GUARD); end
    step();
    idle_inputs();
    #1;
    n_cmp++; if (wr_blocked !== GUARD) begin n_err++; $display("FAIL collide_wr_blocked: got %b want %b", wr_blocked, GUARD); end
    n_cmp++; if (guard_active !== 1'b0) begin n_err++; $display("FAIL collide_open: got %b want 0", guard_active); end
    m1_req = 1; m1_we = 1; m1_addr = 13'h0021; m1_wdata = 16'h5678; m1_wmask = 16'h00FF;
    #1;
    n_cmp++; if (ram_we !== 1'b1) begin n_err++; $display("FAIL collide_next_we: got %b want 1", ram_we); end
    step();
    idle_inputs();
    #1;
    n_cmp++; if (mem[13'h0021] !== 16'h5600) begin n_err++; $display("FAIL collide_masked_mem: got %h want 5600", mem[13'h0021]); end
    n_cmp++; if (wr_blocked !== GUARD) begin n_err++; $display("FAIL collide_sticky: got %b want %b", wr_blocked, GUARD); end
  endtask

  task automatic test_reset_mid_read();
    m1_req = 1; m1_we = 0; m1_addr = 13'h0002;
    step();
    idle_inputs();
    m0_req = 1; m0_we = 0; m0_addr = 13'h0005;
    step();
    rst_n = 0;
    m0_req = 1; m1_req = 1;
    #1;
    n_cmp++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_err++; $display("FAIL midrst_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end
    n_cmp++; if (guard_active !== GUARD) begin n_err++; $display("FAIL midrst_guard: got %b want %b", guard_active, GUARD); end
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_err++; $display("FAIL midrst_gnt: got %b want 00", {m0_gnt, m1_gnt}); end
    step();
    rst_n = 1;
    #1;
    n_cmp++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_err++; $display("FAIL post_rst_gnt: got %b want 10", {m0_gnt, m1_gnt}); end
    n_cmp++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_err++; $display("FAIL post_rst_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end
    step();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    test_reset();
    test_single_read();
    test_contention();
    test_guard();
    test_release_collision();
    test_reset_mid_read();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1);
  end
endmodule
